// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, counter widths and transmitter states.
package uart_pkg;

    localparam int UART_OVERSAMPLE       = 8;
    localparam int UART_OVERSAMPLE_SHIFT = 3;
    localparam int PRESCALE_W            = 16;
    localparam int PERIOD_W              = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // One bit period in clk cycles; a prescale of zero behaves as one.
    function automatic logic [PERIOD_W-1:0] bit_period(input logic [PRESCALE_W-1:0] prescale);
        logic [PRESCALE_W-1:0] eff;
        if (prescale == {PRESCALE_W{1'b0}}) begin
            eff = {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end else begin
            eff = prescale;
        end
        return PERIOD_W'(eff) << UART_OVERSAMPLE_SHIFT;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: AXI-Stream word in, 8N1/8N2 frame out on txd, LSB first.
// A one-word holding register keeps back-to-back frames gapless.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  stop_bits
);

    localparam logic [PERIOD_W-1:0] CNT_ZERO  = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] CNT_ONE   = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]          BITS_INIT = 4'(DATA_WIDTH);

    uart_tx_state_t        state_r, state_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_s;
    logic [DATA_WIDTH-1:0] shift_nxt_s;
    logic [DATA_WIDTH-1:0] hold_r, hold_s;
    logic                  hold_valid_r, hold_valid_s;
    logic                  tready_r, tready_s;
    logic                  txd_r, txd_s;
    logic                  busy_r, busy_s;
    logic [PERIOD_W-1:0]   period_r, period_s;
    logic [PERIOD_W-1:0]   cnt_r, cnt_s;
    logic [3:0]            bit_cnt_r, bit_cnt_s;
    logic                  stop2_r, stop2_s;
    logic                  load_s;
    logic                  hs_s;
    logic                  cnt_done_s;

    // State and datapath register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            shift_r      <= {DATA_WIDTH{1'b0}};
            hold_r       <= {DATA_WIDTH{1'b0}};
            hold_valid_r <= 1'b0;
            tready_r     <= 1'b0;
            txd_r        <= 1'b1;
            busy_r       <= 1'b0;
            period_r     <= CNT_ZERO;
            cnt_r        <= CNT_ZERO;
            bit_cnt_r    <= 4'd0;
            stop2_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            hold_r       <= hold_s;
            hold_valid_r <= hold_valid_s;
            tready_r     <= tready_s;
            txd_r        <= txd_s;
            busy_r       <= busy_s;
            period_r     <= period_s;
            cnt_r        <= cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            stop2_r      <= stop2_s;
        end
    end

    // Next-state, counters, holding register and output levels.
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        hold_s       = hold_r;
        hold_valid_s = hold_valid_r;
        txd_s        = txd_r;
        busy_s       = busy_r;
        period_s     = period_r;
        cnt_s        = cnt_r;
        bit_cnt_s    = bit_cnt_r;
        stop2_s      = stop2_r;
        load_s       = 1'b0;
        shift_nxt_s  = shift_r >> 1;
        hs_s         = s_axis_tvalid && tready_r;
        cnt_done_s   = (cnt_r == CNT_ZERO);

        case (state_r)
            IDLE: begin
                txd_s  = 1'b1;
                busy_s = 1'b0;
                if (hold_valid_r) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            START: begin
                if (cnt_done_s) begin
                    state_s   = DATA;
                    txd_s     = shift_r[0];
                    cnt_s     = period_r - CNT_ONE;
                    bit_cnt_s = BITS_INIT;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            DATA: begin
                if (!cnt_done_s) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (bit_cnt_r == 4'd1) begin
                    // bit_cnt is reused in STOP as the number of stop bits still to send
                    state_s   = STOP;
                    txd_s     = 1'b1;
                    cnt_s     = period_r - CNT_ONE;
                    bit_cnt_s = stop2_r ? 4'd2 : 4'd1;
                end else begin
                    shift_s   = shift_nxt_s;
                    txd_s     = shift_nxt_s[0];
                    cnt_s     = period_r - CNT_ONE;
                    bit_cnt_s = bit_cnt_r - 4'd1;
                end
            end
            STOP: begin
                if (!cnt_done_s) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (bit_cnt_r == 4'd2) begin
                    bit_cnt_s = 4'd1;
                    cnt_s     = period_r - CNT_ONE;
                end else if (hold_valid_r) begin
                    load_s = 1'b1;
                end else begin
                    state_s = IDLE;
                    txd_s   = 1'b1;
                    busy_s  = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
                txd_s   = 1'b1;
                busy_s  = 1'b0;
            end
        endcase

        // tready is low whenever the holding register is full, so load and handshake never coincide
        if (load_s) begin
            shift_s      = hold_r;
            hold_valid_s = 1'b0;
            period_s     = bit_period(prescale);
            cnt_s        = bit_period(prescale) - CNT_ONE;
            stop2_s      = stop_bits;
            txd_s        = 1'b0;
            busy_s       = 1'b1;
            state_s      = START;
        end else if (hs_s) begin
            hold_s       = s_axis_tdata;
            hold_valid_s = 1'b1;
        end else begin
            hold_valid_s = hold_valid_r;
        end

        tready_s = !hold_valid_s;
    end

    assign s_axis_tready = tready_r;
    assign txd           = txd_r;
    assign busy          = busy_r;

endmodule
